// File: rtl/lpc_reg_bank.sv
// LPC-side register bank: per-bit R/W, W1C, read-clear, HW-live and HW-sticky-set attributes,
// registered read port and status/enable interrupt. Optional write lock: define LPC_REG_WRLOCK_EN.

module lpc_reg_bank_reg #(
  parameter logic [7:0] RST   = 8'h00,
  parameter logic [7:0] WRM   = 8'hFF,
  parameter logic [7:0] W1CM  = 8'h00,
  parameter logic [7:0] RCM   = 8'h00,
  parameter logic [7:0] LIVEM = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [7:0] i_din,
  input  logic [7:0] i_hwset,
  input  logic [7:0] i_hwlive,
  output logic [7:0] o_q
);
  // W1C takes precedence, so plain-write bits exclude W1C bits
  localparam logic [7:0] WRB = WRM & ~W1CM;

  logic [7:0] r_q;
  logic [7:0] w_nxt;

  always_comb begin
    w_nxt = r_q;
    if (i_wr)
      w_nxt = (r_q & ~(W1CM & i_din) & ~WRB) | (i_din & WRB);
    if (i_rd)
      w_nxt = w_nxt & ~RCM;
    w_nxt = w_nxt | i_hwset;
    w_nxt = (w_nxt & ~LIVEM) | (i_hwlive & LIVEM);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_q <= RST;
    else          r_q <= w_nxt;
  end

  assign o_q = r_q;
endmodule

module lpc_reg_bank #(
  parameter int                      NUM_REGS      = 32,
  parameter int                      ADDR_W        = 8,
  parameter logic [NUM_REGS*8-1:0]   RST_VAL       = '0,
  parameter logic [NUM_REGS*8-1:0]   WR_MASK       = '1,
  parameter logic [NUM_REGS*8-1:0]   W1C_MASK      = '0,
  parameter logic [NUM_REGS*8-1:0]   RC_MASK       = '0,
  parameter logic [NUM_REGS*8-1:0]   LIVE_MASK     = '0,
  parameter int                      IRQ_STAT_ADDR = 8'h0B,
  parameter int                      IRQ_EN_ADDR   = 8'h09,
  parameter int                      LOCK_ADDR     = 8'h04,
  parameter int                      LOCK_BIT      = 4,
  parameter logic [NUM_REGS-1:0]     LOCK_MASK     = '0
) (
  input  logic                  i_LpcClock,
  input  logic                  i_PciReset,
  input  logic [ADDR_W-1:0]     i_Addr,
  input  logic                  i_Wr,
  input  logic                  i_Rd,
  input  logic [7:0]            i_DataWr,
  input  logic [NUM_REGS*8-1:0] i_HwSet,
  input  logic [NUM_REGS*8-1:0] i_HwLive,
  output logic [NUM_REGS*8-1:0] o_RegOut,
  output logic [7:0]            o_RdData,
  output logic                  o_RdValid,
  output logic                  o_Irq
);
`ifdef LPC_REG_WRLOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int                NSLOT    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] STAT_IDX = ADDR_W'(IRQ_STAT_ADDR);
  localparam logic [ADDR_W-1:0] EN_IDX   = ADDR_W'(IRQ_EN_ADDR);
  localparam logic [ADDR_W-1:0] LOCK_IDX = ADDR_W'(LOCK_ADDR);
  // The lock register always protects itself so only reset can drop the lock
  localparam logic [NUM_REGS-1:0] PROT   = LOCK_MASK | (NUM_REGS'(1) << LOCK_ADDR);

  logic [NSLOT-1:0][7:0]   w_rdmux;
  logic [NUM_REGS-1:0]     w_wr_hit;
  logic [NUM_REGS-1:0]     w_rd_hit;
  logic                    w_lock;
  logic [7:0]              r_RdData;
  logic                    r_RdValid;
  logic                    r_Irq;

  assign w_lock = LOCK_EN & w_rdmux[LOCK_IDX][LOCK_BIT];

  genvar k;
  generate
    for (k = 0; k < NUM_REGS; k++) begin : g_reg
      assign w_wr_hit[k] = i_Wr & (i_Addr == ADDR_W'(k)) & ~(w_lock & PROT[k]);
      assign w_rd_hit[k] = i_Rd & (i_Addr == ADDR_W'(k));

      lpc_reg_bank_reg #(
        .RST  (RST_VAL  [8*k +: 8]),
        .WRM  (WR_MASK  [8*k +: 8]),
        .W1CM (W1C_MASK [8*k +: 8]),
        .RCM  (RC_MASK  [8*k +: 8]),
        .LIVEM(LIVE_MASK[8*k +: 8])
      ) u_reg (
        .i_clk   (i_LpcClock),
        .i_rst_n (i_PciReset),
        .i_wr    (w_wr_hit[k]),
        .i_rd    (w_rd_hit[k]),
        .i_din   (i_DataWr),
        .i_hwset (i_HwSet [8*k +: 8]),
        .i_hwlive(i_HwLive[8*k +: 8]),
        .o_q     (o_RegOut[8*k +: 8])
      );
    end

    // Unpopulated address slots read back as all-ones
    for (k = 0; k < NSLOT; k++) begin : g_mux
      if (k < NUM_REGS) begin : g_pop
        assign w_rdmux[k] = o_RegOut[8*k +: 8];
      end else begin : g_empty
        assign w_rdmux[k] = 8'hFF;
      end
    end
  endgenerate

  always_ff @(posedge i_LpcClock) begin
    if (!i_PciReset) begin
      r_RdData  <= 8'h00;
      r_RdValid <= 1'b0;
      r_Irq     <= 1'b0;
    end else begin
      r_RdValid <= i_Rd;
      if (i_Rd) r_RdData <= w_rdmux[i_Addr];
      r_Irq     <= |(w_rdmux[STAT_IDX] & w_rdmux[EN_IDX]);
    end
  end

  assign o_RdData  = r_RdData;
  assign o_RdValid = r_RdValid;
  assign o_Irq     = r_Irq;
endmodule

// File: tb/tb_lpc_reg_bank.sv
// Bench for lpc_reg_bank: directed scenarios plus random traffic against a per-bit reference model.
module tb_lpc_reg_bank;
  localparam int N  = 16;
  localparam int AW = 5;
  localparam logic [N*8-1:0] P_RST  = 128'h78563412_00C30077_005A0000_0081003C;
  localparam logic [N*8-1:0] P_WR   = 128'hFFFFFFFF_00FFFFFF_FFFF00FF_0F000FFF;
  localparam logic [N*8-1:0] P_W1C  = 128'h00000000_FEF00000_0000FF00_00000000;
  localparam logic [N*8-1:0] P_RC   = 128'h0000000F_01000000_00000000_00000000;
  localparam logic [N*8-1:0] P_LIVE = 128'h00000100_00000000_00000000_0000F000;
  localparam logic [N-1:0]   P_LOCK = 16'h0140;
`ifdef LPC_REG_WRLOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr = 1'b0, rd = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [7:0]     din = '0;
  logic [N*8-1:0] hwset = '0, hwlive = '0;
  logic [N*8-1:0] regout;
  logic [7:0]     rddata;
  logic           rdvalid, irq;

  logic [7:0] m_reg [N];
  logic [7:0] m_rddata;
  logic       m_rdvalid, m_irq;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  lpc_reg_bank #(
    .NUM_REGS(N), .ADDR_W(AW), .RST_VAL(P_RST), .WR_MASK(P_WR), .W1C_MASK(P_W1C),
    .RC_MASK(P_RC), .LIVE_MASK(P_LIVE), .IRQ_STAT_ADDR(11), .IRQ_EN_ADDR(9),
    .LOCK_ADDR(4), .LOCK_BIT(4), .LOCK_MASK(P_LOCK)
  ) dut (
    .i_LpcClock(clk), .i_PciReset(rst_n), .i_Addr(addr), .i_Wr(wr), .i_Rd(rd),
    .i_DataWr(din), .i_HwSet(hwset), .i_HwLive(hwlive), .o_RegOut(regout),
    .o_RdData(rddata), .o_RdValid(rdvalid), .o_Irq(irq)
  );

  function automatic logic [N*8-1:0] m_vec();
    logic [N*8-1:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = m_reg[k];
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model from the spec rules, step past the edge.
  task automatic tick(input bit r_n, input bit w, input bit r, input int a,
                      input logic [7:0] d, input logic [N*8-1:0] hs);
    logic [7:0] nxt [N];
    logic v, lk, prot;
    rst_n = r_n; wr = w; rd = r; addr = AW'(a); din = d; hwset = hs;
    hwlive = {$urandom, $urandom, $urandom, $urandom};
    if (!r_n) begin
      for (int k = 0; k < N; k++) m_reg[k] = P_RST[8*k +: 8];
      m_rddata = 8'h00; m_rdvalid = 1'b0; m_irq = 1'b0;
    end else begin
      m_irq = |(m_reg[11] & m_reg[9]);
      m_rdvalid = r;
      if (r) m_rddata = (a < N) ? m_reg[a] : 8'hFF;
      lk = LOCK_ON && m_reg[4][4];
      for (int k = 0; k < N; k++) begin
        prot = lk && (P_LOCK[k] || k == 4);
        for (int b = 0; b < 8; b++) begin
          v = m_reg[k][b];
          if (w && a == k && !prot) begin
            if (P_W1C[8*k+b]) begin if (d[b]) v = 1'b0; end
            else if (P_WR[8*k+b]) v = d[b];
          end
          if (r && a == k && P_RC[8*k+b]) v = 1'b0;
          if (hs[8*k+b]) v = 1'b1;
          if (P_LIVE[8*k+b]) v = hwlive[8*k+b];
          nxt[k][b] = v;
        end
      end
      m_reg = nxt;
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; hwset = '0; rst_n = 1'b1;
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00, '0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1, 2, 8'hAA, '1);
    tick(1'b0, 1'b0, 1'b0, 0, 8'h00, '0);
    total++; if (regout !== P_RST) $display("FAIL reset_regs got=%h exp=%h", regout, P_RST); else passed++;
    total++; if (rddata !== 8'h00) $display("FAIL reset_rddata got=%h exp=00", rddata); else passed++;
    total++; if (rdvalid !== 1'b0) $display("FAIL reset_rdvalid got=%b exp=0", rdvalid); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passed++;
  endtask

  task automatic test_read_all();
    logic [7:0] e, held;
    for (int a = 0; a <= N; a++) begin
      e = (a < N) ? P_RST[8*a +: 8] : 8'hFF;
      tick(1'b1, 1'b0, 1'b1, a, 8'h00, '0);
      held = rddata;
      total++;
      if (rdvalid !== 1'b1 || rddata !== m_rddata ||
          ((rddata ^ e) & ~((a < N) ? P_LIVE[8*a +: 8] : 8'h00)) !== 8'h00)
        $display("FAIL read_all[%0d] data=%h exp=%h valid=%b exp=1", a, rddata, m_rddata, rdvalid);
      else passed++;
      idle();
      total++;
      if (rdvalid !== 1'b0 || rddata !== held)
        $display("FAIL read_hold[%0d] data=%h exp=%h valid=%b exp=0", a, rddata, held, rdvalid);
      else passed++;
    end
  endtask

  task automatic test_wr_mask();
    tick(1'b1, 1'b1, 1'b0, 3, 8'hFF, '0);
    total++; if (regout[31:24] !== 8'h0F) $display("FAIL wr_mask got=%h exp=0f", regout[31:24]); else passed++;
  endtask

  task automatic test_w1c();
    logic [N*8-1:0] hs;
    hs = '0; hs[47:40] = 8'hA5;
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00, hs);
    total++; if (regout[47:40] !== 8'hA5) $display("FAIL w1c_set got=%h exp=a5", regout[47:40]); else passed++;
    tick(1'b1, 1'b1, 1'b0, 5, 8'h05, '0);
    total++; if (regout[47:40] !== 8'hA0) $display("FAIL w1c_clear got=%h exp=a0", regout[47:40]); else passed++;
  endtask

  task automatic test_rc();
    logic [N*8-1:0] hs;
    hs = '0; hs[88] = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00, hs);
    tick(1'b1, 1'b0, 1'b1, 11, 8'h00, '0);
    total++;
    if (rddata[0] !== 1'b1 || regout[88] !== 1'b0)
      $display("FAIL rc_clear rd0=%b exp=1 reg0=%b exp=0", rddata[0], regout[88]);
    else passed++;
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00, hs);
    tick(1'b1, 1'b0, 1'b1, 11, 8'h00, hs);
    total++;
    if (rddata[0] !== 1'b1 || regout[88] !== 1'b1)
      $display("FAIL rc_hwset rd0=%b exp=1 reg0=%b exp=1", rddata[0], regout[88]);
    else passed++;
  endtask

  task automatic test_irq();
    logic [N*8-1:0] hs;
    tick(1'b1, 1'b1, 1'b0, 11, 8'hFF, '0);
    tick(1'b1, 1'b0, 1'b1, 11, 8'h00, '0);
    tick(1'b1, 1'b1, 1'b0, 9, 8'h00, '0);
    hs = '0; hs[90] = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00, hs);
    idle();
    total++; if (regout[95:88] !== 8'h04 || irq !== 1'b0)
      $display("FAIL irq_idle stat=%h exp=04 irq=%b exp=0", regout[95:88], irq); else passed++;
    tick(1'b1, 1'b1, 1'b0, 9, 8'h04, '0);
    total++; if (irq !== 1'b0) $display("FAIL irq_en_edge got=%b exp=0", irq); else passed++;
    idle();
    total++; if (irq !== 1'b1) $display("FAIL irq_assert got=%b exp=1", irq); else passed++;
    tick(1'b1, 1'b1, 1'b0, 11, 8'h04, '0);
    total++; if (irq !== 1'b1 || regout[90] !== 1'b0)
      $display("FAIL irq_w1c_edge irq=%b exp=1 stat2=%b exp=0", irq, regout[90]); else passed++;
    idle();
    total++; if (irq !== 1'b0) $display("FAIL irq_deassert got=%b exp=0", irq); else passed++;
  endtask

  task automatic test_rw_same();
    logic [7:0] old;
    old = m_reg[0];
    tick(1'b1, 1'b1, 1'b1, 0, 8'h12, '0);
    total++; if (rddata !== old || regout[7:0] !== 8'h12)
      $display("FAIL rw_same rd=%h exp=%h reg=%h exp=12", rddata, old, regout[7:0]); else passed++;
  endtask

  task automatic test_back_to_back();
    int seq [4] = '{8, 9, 20, 12};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, seq[i], 8'h00, '0);
      total++; if (rdvalid !== 1'b1 || rddata !== m_rddata)
        $display("FAIL b2b[%0d] data=%h exp=%h valid=%b exp=1", i, rddata, m_rddata, rdvalid); else passed++;
    end
    idle();
    total++; if (rdvalid !== 1'b0 || rddata !== m_rddata)
      $display("FAIL b2b_end data=%h exp=%h valid=%b exp=0", rddata, m_rddata, rdvalid); else passed++;
  endtask

  task automatic test_random();
    logic [N*8-1:0] hs;
    for (int i = 0; i < 400; i++) begin
      hs = {4{$urandom}} & {4{$urandom}} & {4{$urandom}} & {4{$urandom}};
      tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
           8'($urandom), hs);
      total++;
      if (regout !== m_vec() || rddata !== m_rddata || rdvalid !== m_rdvalid || irq !== m_irq)
        $display("FAIL random[%0d] regs=%h exp=%h rd=%h exp=%h v=%b exp=%b irq=%b exp=%b",
                 i, regout, m_vec(), rddata, m_rddata, rdvalid, m_rdvalid, irq, m_irq);
      else passed++;
    end
  endtask

`ifdef LPC_REG_WRLOCK_EN
  task automatic test_lock();
    logic [7:0] r6;
    logic [N*8-1:0] hs;
    tick(1'b1, 1'b1, 1'b0, 4, 8'h10, '0);
    tick(1'b1, 1'b1, 1'b0, 4, 8'h00, '0);
    total++; if (regout[36] !== 1'b1) $display("FAIL lock_self got=%b exp=1", regout[36]); else passed++;
    r6 = regout[55:48];
    tick(1'b1, 1'b1, 1'b0, 6, ~r6, '0);
    total++; if (regout[55:48] !== r6) $display("FAIL lock_reg6 got=%h exp=%h", regout[55:48], r6); else passed++;
    hs = '0; hs[48] = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00, hs);
    total++; if (regout[48] !== 1'b1) $display("FAIL lock_hwset got=%b exp=1", regout[48]); else passed++;
    tick(1'b1, 1'b1, 1'b0, 0, 8'h33, '0);
    total++; if (regout[7:0] !== 8'h33) $display("FAIL lock_free got=%h exp=33", regout[7:0]); else passed++;
    tick(1'b0, 1'b0, 1'b0, 0, 8'h00, '0);
    total++; if (regout[39:32] !== 8'h00) $display("FAIL lock_reset got=%h exp=00", regout[39:32]); else passed++;
  endtask
`endif

  task automatic test_midreset();
    logic [N*8-1:0] hs;
    tick(1'b1, 1'b1, 1'b0, 9, 8'hFF, '0);
    hs = '0; hs[91] = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 0, 8'h00, hs);
    tick(1'b1, 1'b1, 1'b0, 0, 8'h99, '0);
    total++; if (irq !== 1'b1) $display("FAIL midrst_pre irq=%b exp=1", irq); else passed++;
    tick(1'b0, 1'b1, 1'b1, 0, 8'h55, '1);
    total++; if (regout !== P_RST || rdvalid !== 1'b0 || irq !== 1'b0 || rddata !== 8'h00)
      $display("FAIL midrst regs=%h exp=%h v=%b irq=%b rd=%h exp 0", regout, P_RST, rdvalid, irq, rddata);
    else passed++;
    idle();
    total++; if (regout !== m_vec() || irq !== m_irq)
      $display("FAIL midrst_after regs=%h exp=%h irq=%b exp=%b", regout, m_vec(), irq, m_irq); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_wr_mask();
    test_w1c();
    test_rc();
    test_irq();
    test_rw_same();
    test_back_to_back();
    test_random();
`ifdef LPC_REG_WRLOCK_EN
    test_lock();
`endif
    test_midreset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
